magic_button_ctrl: RTL and testbench

- Produces the `magic_button` request consumed by the magic/NMI controller.
- Synchronises and debounces the front-panel MAGIC key and raises a level request.
- Holds the request until the controller acknowledges it by raising `magic_mode`, or until a timeout expires.
- Also reports a long-press reboot request.
- Sits between the board pin and the magic controller, clocked by the 28 MHz system clock.

---
 rtl/common.sv | 14 +
 rtl/debounce.sv | 40 ++++
 rtl/magic_button_ctrl.sv | 105 ++++++++++
 tb/tb_magic_button_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/common.sv
// common: shared FSM encoding and default cycle constants for the magic key path
package common;

   typedef enum logic [1:0] {
      MB_IDLE,
      MB_REQ,
      MB_HOLD
   } magic_btn_state_t;

   localparam int MAGIC_DEBOUNCE_CYC = 560000;
   localparam int MAGIC_LONG_CYC     = 56000000;
   localparam int MAGIC_TIMEOUT_CYC  = 2800000;

endpackage

// File: rtl/debounce.sv
// debounce: 2-FF synchroniser plus stability counter for an asynchronous panel key
module debounce #(
   parameter int   CYC  = 4,
   parameter logic IDLE = 1'b1
) (
   input  logic clk28,
   input  logic rst,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(CYC + 1);

   logic          s1, s2, flip;
   logic [CW-1:0] cnt;

   assign flip = (s2 != out) && (cnt == CW'(CYC - 1));

   // synchronise, then flip the stable level once the sample has differed for CYC cycles
   always_ff @(posedge clk28) begin
      if (rst) begin
         s1   <= IDLE;
         s2   <= IDLE;
         out  <= IDLE;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= in;
         s2   <= s1;
         cnt  <= (s2 == out || flip) ? '0 : cnt + 1'b1;
         out  <= flip ? ~out : out;
         rise <= flip && !out;
         fall <= flip && out;
      end
   end

endmodule

// File: rtl/magic_button_ctrl.sv
// magic_button_ctrl: debounced MAGIC key to level request with ack/timeout and long-press reboot (MAGIC_KBD_HOTKEY_EN adds the keyboard hotkey source)
module magic_button_ctrl
   import common::*;
#(
   parameter int DEBOUNCE_CYC = MAGIC_DEBOUNCE_CYC,
   parameter int LONG_CYC     = MAGIC_LONG_CYC,
   parameter int TIMEOUT_CYC  = MAGIC_TIMEOUT_CYC
) (
   input  logic clk28,
   input  logic rst,
   input  logic button_n,
   input  logic kbd_magic,
   input  logic magic_mode,
   output logic magic_button,
   output logic reboot_req,
   output logic btn_pressed,
   output logic req_timeout
);

   localparam int GUARD = DEBOUNCE_CYC + 2;
   localparam int GW    = $clog2(GUARD + 1);
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);
   localparam int LW    = $clog2(LONG_CYC + 1);

   magic_btn_state_t state, nstate;
   logic              key_lvl, press_ev, unused_rise;
   logic              armed, req_ev, expire;
   logic [GW-1:0]     guard;
   logic [TW-1:0]     tcnt;
   logic [LW-1:0]     lcnt;

   debounce #(.CYC(DEBOUNCE_CYC), .IDLE(1'b1)) u_key (
      .clk28 (clk28),
      .rst   (rst),
      .in    (button_n),
      .out   (key_lvl),
      .rise  (unused_rise),
      .fall  (press_ev)
   );

   assign btn_pressed  = ~key_lvl;
   assign magic_button = (state == MB_REQ);

`ifdef MAGIC_KBD_HOTKEY_EN
   assign req_ev = (press_ev && armed) || kbd_magic;
`else
   logic unused_kbd;
   assign unused_kbd = kbd_magic;
   assign req_ev     = press_ev && armed;
`endif

   // a key held through reset reaches the stable state only after GUARD cycles; arm only if released by then
   always_ff @(posedge clk28) begin
      if (rst) begin
         guard <= '0;
         armed <= 1'b0;
      end else begin
         guard <= (guard == GW'(GUARD)) ? guard : guard + 1'b1;
         armed <= armed | (guard == GW'(GUARD) && !btn_pressed);
      end
   end

   // request FSM next state; expire flags a timeout that lost no race against the acknowledge
   always_comb begin
      nstate = state;
      expire = 1'b0;
      case (state)
         MB_IDLE: nstate = (req_ev && !magic_mode) ? MB_REQ : MB_IDLE;
         MB_REQ: begin
            if (magic_mode) nstate = MB_HOLD;
            else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
               nstate = MB_IDLE;
               expire = 1'b1;
            end
         end
         MB_HOLD: nstate = btn_pressed ? MB_HOLD : MB_IDLE;
         default: nstate = MB_IDLE;
      endcase
   end

   // state, timeout counter (zero outside REQ, so cleared on entry) and sticky timeout flag
   always_ff @(posedge clk28) begin
      if (rst) begin
         state       <= MB_IDLE;
         tcnt        <= '0;
         req_timeout <= 1'b0;
      end else begin
         state       <= nstate;
         tcnt        <= (state == MB_REQ) ? tcnt + 1'b1 : '0;
         req_timeout <= req_timeout | expire;
      end
   end

   // long-press counter saturates at LONG_CYC so the reboot pulse fires once per press
   always_ff @(posedge clk28) begin
      if (rst) begin
         lcnt       <= '0;
         reboot_req <= 1'b0;
      end else begin
         lcnt       <= !btn_pressed ? '0 : (lcnt == LW'(LONG_CYC)) ? lcnt : lcnt + 1'b1;
         reboot_req <= btn_pressed && (lcnt == LW'(LONG_CYC - 1));
      end
   end

endmodule

// File: tb/tb_magic_button_ctrl.sv
// tb_magic_button_ctrl: directed bench for magic_button_ctrl with DEBOUNCE=4, LONG=20, TIMEOUT=10
module tb_magic_button_ctrl;
   import common::*;

   logic clk28 = 1'b0;
   logic rst = 1'b1, button_n = 1'b1, kbd_magic = 1'b0, magic_mode = 1'b0;
   logic magic_button, reboot_req, btn_pressed, req_timeout;
   int   n_chk = 0, n_pass = 0;
   int   mb_cnt, mb_first, btn_cnt, btn_first, rb_cnt, rb_first;

`ifdef MAGIC_KBD_HOTKEY_EN
   localparam logic KBD_EXP = 1'b1;
`else
   localparam logic KBD_EXP = 1'b0;
`endif

   magic_button_ctrl #(.DEBOUNCE_CYC(4), .LONG_CYC(20), .TIMEOUT_CYC(10)) dut (
      .clk28        (clk28),
      .rst          (rst),
      .button_n     (button_n),
      .kbd_magic    (kbd_magic),
      .magic_mode   (magic_mode),
      .magic_button (magic_button),
      .reboot_req   (reboot_req),
      .btn_pressed  (btn_pressed),
      .req_timeout  (req_timeout)
   );

   always #5 clk28 = ~clk28;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk28);
   endtask

   // observe n cycles, recording count and first cycle index of each output pulse/level
   task automatic watch(input int n);
      mb_cnt = 0; mb_first = -1; btn_cnt = 0; btn_first = -1; rb_cnt = 0; rb_first = -1;
      for (int i = 1; i <= n; i++) begin
         step(1);
         if (magic_button) begin if (mb_cnt == 0) mb_first = i; mb_cnt++; end
         if (btn_pressed) begin if (btn_cnt == 0) btn_first = i; btn_cnt++; end
         if (reboot_req) begin if (rb_cnt == 0) rb_first = i; rb_cnt++; end
      end
   endtask

   initial begin
      step(3);
      chk("rst_mb", magic_button, 0);
      chk("rst_reboot", reboot_req, 0);
      chk("rst_btn", btn_pressed, 0);
      chk("rst_timeout", req_timeout, 0);
      rst = 1'b0;
      step(10);
      button_n = 1'b0;
      step(3);
      button_n = 1'b1;
      watch(12);
      chk("glitch_btn", btn_cnt, 0);
      chk("glitch_mb", mb_cnt, 0);
      button_n = 1'b0;
      step(5);
      chk("ack_btn_early", btn_pressed, 0);
      step(1);
      chk("ack_btn", btn_pressed, 1);
      chk("ack_mb_early", magic_button, 0);
      step(1);
      chk("ack_mb", magic_button, 1);
      step(3);
      chk("ack_mb_held", magic_button, 1);
      magic_mode = 1'b1;
      step(1);
      chk("ack_mb_drop", magic_button, 0);
      chk("ack_hold", dut.state, MB_HOLD);
      magic_mode = 1'b0;
      step(2);
      chk("ack_hold_keyheld", dut.state, MB_HOLD);
      chk("ack_mb_hold", magic_button, 0);
      button_n = 1'b1;
      step(8);
      chk("ack_idle", dut.state, MB_IDLE);
      chk("ack_btn_rel", btn_pressed, 0);
      chk("ack_no_timeout", req_timeout, 0);
      button_n = 1'b0;
      watch(30);
      chk("to_btn_first", btn_first, 6);
      chk("to_mb_first", mb_first, 7);
      chk("to_mb_cycles", mb_cnt, 10);
      chk("to_timeout", req_timeout, 1);
      chk("to_mb_end", magic_button, 0);
      chk("lp_rb_first", rb_first, 26);
      chk("lp_rb_count", rb_cnt, 1);
      button_n = 1'b1;
      step(10);
      chk("lp_released", btn_pressed, 0);
      button_n = 1'b0;
      watch(30);
      chk("lp2_rb_first", rb_first, 26);
      chk("lp2_rb_count", rb_cnt, 1);
      chk("lp2_mb_cycles", mb_cnt, 10);
      button_n = 1'b1;
      step(10);
      kbd_magic = 1'b1;
      step(1);
      kbd_magic = 1'b0;
      chk("kbd_mb", magic_button, KBD_EXP);
      magic_mode = 1'b1;
      step(2);
      chk("kbd_idle", dut.state, MB_IDLE);
      kbd_magic = 1'b1;
      step(1);
      kbd_magic = 1'b0;
      chk("kbd_ack_mb", magic_button, 0);
      step(1);
      chk("kbd_ack_idle", dut.state, MB_IDLE);
      magic_mode = 1'b0;
      step(2);
      button_n = 1'b0;
      step(7);
      chk("rstreq_mb", magic_button, 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rstreq_mb_drop", magic_button, 0);
      chk("rstreq_timeout", req_timeout, 0);
      watch(20);
      chk("rstreq_btn_first", btn_first, 6);
      chk("rstreq_no_req", mb_cnt, 0);
      button_n = 1'b1;
      step(10);
      button_n = 1'b0;
      step(7);
      chk("rstreq_repress_mb", magic_button, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
